// File: rtl/frame_fifo_pkg.sv
// Shared Avalon-ST word types, FIFO entry layout and write-FSM states for frame_fifo.
package frame_fifo_pkg;

  localparam int B                = 8;
  localparam int BpW              = 4;
  localparam int EW               = $clog2(BpW);
  localparam int FRAME_FIFO_DEPTH = 512;

  typedef logic [B*BpW-1:0] Word;

  // Forward-direction stream fields; ready travels the other way as its own signal.
  typedef struct packed {
    Word             data;
    logic            valid;
    logic            sop;
    logic            eop;
    logic [EW-1:0]   empty;
  } avln_st;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic [EW-1:0]   empty;
    Word             data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_FRAME   = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_fifo_ram.sv
// Simple dual-port storage for frame_fifo: one write port, one read port with a registered read.
module frame_fifo_ram #(
  parameter int AW = 9,
  parameter int DW = 36
) (
  input  logic          sys_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset; entries are only read after being written,
  // and leaving reset off lets the tools map it onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_fifo.sv
// Store-and-forward Avalon-ST packet FIFO: a frame is released only once its eop word is stored.
// Optional FRAME_FIFO_DROP_EN: never backpressure, drop frames that do not fit instead.
module frame_fifo
  import frame_fifo_pkg::*;
#(
  parameter  int DEPTH  = FRAME_FIFO_DEPTH,
  parameter  int MAXFRM = 64,
  localparam int AW     = $clog2(DEPTH),
  localparam int FCW    = $clog2(MAXFRM + 1)
) (
  input  logic           sys_clk,
  input  logic           reset_n,
  input  logic           clr,
  input  Word            in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sop,
  input  logic           in_eop,
  input  logic [EW-1:0]  in_empty,
  output Word            out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sop,
  output logic           out_eop,
  output logic [EW-1:0]  out_empty,
  output logic [FCW-1:0] frames,
  output logic [15:0]    drops,
  output logic [AW:0]    level
);

  typedef logic [AW:0] ptr_t;

  wr_state_t   state;
  ptr_t        wr_ptr, cmt_ptr, cmt_vis, rd_ptr;
  ptr_t        wr_base, rd_nxt;
  logic        cut_thru;
  fifo_entry_t wr_entry, ram_q, out_q;

  logic full, frm_full, accept, restart, overflow, reject, store;
  logic commit, rel_frm, drop_frame, ct_start, load, pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == ptr_t'(DEPTH));
  assign frm_full = (frames == FCW'(MAXFRM));

`ifdef FRAME_FIFO_DROP_EN
  assign in_ready = 1'b1;
  // A new frame that finds no room is thrown away whole.
  assign reject   = accept & (state == WR_IDLE) & in_sop & (full | frm_full);
  assign overflow = accept & (state == WR_FRAME) & ~in_sop & full;
  assign ct_start = 1'b0;
`else
  // Refusing input at the frame-count limit keeps frames from wrapping.
  assign in_ready = ~full & ~frm_full;
  assign reject   = 1'b0;
  assign overflow = 1'b0;
  // A frame larger than the FIFO would deadlock; stream it through instead.
  assign ct_start = (state == WR_FRAME) & full & (frames == '0) & ~cut_thru;
`endif

  assign accept     = in_valid & in_ready;
  assign restart    = accept & (state == WR_FRAME) & in_sop;
  assign store      = accept & ~reject & ~overflow &
                      (((state == WR_IDLE) & in_sop) | (state == WR_FRAME));
  assign wr_base    = restart ? cmt_ptr : wr_ptr;
  assign commit     = store & in_eop;
  assign drop_frame = restart | overflow | reject;
  assign wr_entry   = '{sop: in_sop, eop: in_eop, empty: in_empty, data: in_data};

  assign pop     = out_valid & out_ready;
  assign rel_frm = pop & out_eop;
  // cmt_vis trails cmt_ptr by the RAM read latency, so a word is only
  // loaded once the RAM output already reflects its write.
  assign load    = (rd_ptr != cmt_vis) & (~out_valid | out_ready);
  assign rd_nxt  = load ? rd_ptr + ptr_t'(1) : rd_ptr;

  frame_fifo_ram #(
    .AW (AW),
    .DW ($bits(fifo_entry_t))
  ) u_ram (
    .sys_clk (sys_clk),
    .wr_en   (store),
    .wr_addr (wr_base[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_nxt[AW-1:0]),
    .rd_data (ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WR_IDLE;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      cut_thru <= 1'b0;
      frames   <= '0;
      drops    <= '0;
    end else if (clr) begin
      state    <= WR_IDLE;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      cut_thru <= 1'b0;
      frames   <= '0;
      drops    <= '0;
    end else begin
      frames <= frames + FCW'(commit) - FCW'(rel_frm);
      if (drop_frame) drops <= sat_inc16(drops);

      if (overflow)   wr_ptr <= cmt_ptr;
      else if (store) wr_ptr <= wr_base + ptr_t'(1);

      if (commit || (store && cut_thru && !restart)) cmt_ptr <= wr_base + ptr_t'(1);
      else if (ct_start)                             cmt_ptr <= wr_ptr;

      if (ct_start)               cut_thru <= 1'b1;
      else if (commit || restart) cut_thru <= 1'b0;

      case (state)
        WR_IDLE: begin
          // Words outside a frame are ignored; a rejected single-word frame needs no discard.
          if (accept && in_sop && !in_eop) state <= reject ? WR_DISCARD : WR_FRAME;
        end
        WR_FRAME: begin
          if (accept) begin
            if (in_eop)        state <= WR_IDLE;
            else if (overflow) state <= WR_DISCARD;
          end
        end
        WR_DISCARD: begin
          if (accept && in_eop) state <= WR_IDLE;
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      cmt_vis   <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (clr) begin
      rd_ptr    <= '0;
      cmt_vis   <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      cmt_vis <= cmt_ptr;
      if (load) begin
        out_q     <= ram_q;
        rd_ptr    <= rd_nxt;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = out_q.data;
  assign out_sop   = out_q.sop;
  assign out_eop   = out_q.eop;
  assign out_empty = out_q.empty;

endmodule
